// File: rtl/mem_stage_ctrl_pkg.sv
// ============================================================================
// Module : mem_stage_ctrl_pkg
// Brief  : LC-3b opcode encoding and MEM-stage access FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_ctrl_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'hA,
    op_sti  = 4'hB,
    op_jmp  = 4'hC,
    op_shf  = 4'hD,
    op_lea  = 4'hE,
    op_trap = 4'hF
  } lc3b_opcode;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t c_IDLE = 2'd0;
  localparam mem_state_t c_IND  = 2'd1;
  localparam mem_state_t c_ACC  = 2'd2;

  function automatic logic is_ind_op(input logic [3:0] op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  function automatic logic is_byte_op(input logic [3:0] op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_load_align.sv
// ============================================================================
// Module : mem_stage_ctrl_load_align
// Brief  : Byte-lane steering: store replication/byte enables, load SEXT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl_load_align (
  input  logic        byte_op,
  input  logic        byte_sel,
  input  logic [15:0] wdata_in,
  input  logic [15:0] rdata_in,
  output logic [1:0]  byte_en,
  output logic [15:0] wdata_out,
  output logic [15:0] rdata_out
);

  always_comb begin
    byte_en   = 2'b11;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    if (byte_op) begin
      // Store byte is replicated on both lanes; the enable picks the target.
      byte_en   = byte_sel ? 2'b10 : 2'b01;
      wdata_out = {wdata_in[7:0], wdata_in[7:0]};
      rdata_out = byte_sel ? {{8{rdata_in[15]}}, rdata_in[15:8]}
                           : {{8{rdata_in[7]}},  rdata_in[7:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module : mem_stage_ctrl
// Brief  : MEM-stage D-memory sequencer (plain, byte and indirect accesses).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_en,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        timeout_err
);

  localparam int unsigned c_CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LIM = c_CNT_W'(WAIT_MAX);
  localparam logic c_TO_EN = (WAIT_MAX != 0);

  mem_state_t         state_q, state_d;
  logic [15:0]        ptr_q, ptr_d;
  logic [c_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic        req;
  logic        ind_op;
  logic        busy;
  logic        timeout;
  logic        done;
  logic [15:0] acc_addr;
  logic        align_byte_op;
  logic [1:0]  align_be;
  logic [15:0] align_wdata;

  assign req     = valid_in & (mem_read | mem_write);
  assign ind_op  = is_ind_op(opcode);
  assign busy    = (state_q != c_IDLE);
  // A real response in the limit cycle wins over the timeout.
  assign timeout = c_TO_EN & busy & ~dmem_resp & (wait_cnt_q == c_WAIT_LIM);
  assign done    = busy & (dmem_resp | timeout);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q | timeout;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    acc_addr      = addr;
    case (state_q)
      c_IDLE: begin
        if (req) state_d = ind_op ? c_IND : c_ACC;
      end
      c_IND: begin
        dmem_read = 1'b1;
        if (done) begin
          ptr_d   = dmem_rdata;
          state_d = c_ACC;
        end
      end
      c_ACC: begin
        acc_addr = ind_op ? ptr_q : addr;
        if (mem_write) dmem_write = 1'b1;
        else           dmem_read  = 1'b1;
        if (done) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
    if (busy && !done) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign align_byte_op = (state_q == c_ACC) & is_byte_op(opcode);

  mem_stage_ctrl_load_align u_align (
    .byte_op   (align_byte_op),
    .byte_sel  (acc_addr[0]),
    .wdata_in  (wdata),
    .rdata_in  (dmem_rdata),
    .byte_en   (align_be),
    .wdata_out (align_wdata),
    .rdata_out (rdata_out)
  );

  assign dmem_addr    = busy ? acc_addr    : 16'h0000;
  assign dmem_wdata   = busy ? align_wdata : 16'h0000;
  assign dmem_byte_en = busy ? align_be    : 2'b00;
  assign stall        = ((state_q == c_IDLE) & req) | (state_q == c_IND) |
                        ((state_q == c_ACC) & ~done);
  assign timeout_err  = timeout_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= c_IDLE;
      ptr_q         <= 16'h0000;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module : tb_mem_stage_ctrl
// Brief  : Directed self-checking bench for mem_stage_ctrl with a memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [3:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_en;
  logic        stall;
  logic [15:0] rdata_out;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WAIT_MAX(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .opcode       (opcode),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .stall        (stall),
    .rdata_out    (rdata_out),
    .timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [int];
  int          resp_wait;
  int          wcnt;

  int          cyc, stall_cnt, rd_cnt, wr_cnt;
  logic        got_first, done;
  logic [15:0] first_addr, last_addr, last_wdata, rdata_cap;
  logic [1:0]  last_be;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    int k;
    k = int'({a[15:1], 1'b0});
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // Memory responder: answers an active strobe after resp_wait idle cycles.
  task automatic respond();
    logic [15:0] w;
    if (dmem_read || dmem_write) begin
      if (wcnt == resp_wait) begin
        dmem_resp = 1'b1;
        if (dmem_write) begin
          w = mem_rd(dmem_addr);
          if (dmem_byte_en[0]) w[7:0]  = dmem_wdata[7:0];
          if (dmem_byte_en[1]) w[15:8] = dmem_wdata[15:8];
          mem[int'({dmem_addr[15:1], 1'b0})] = w;
        end else begin
          dmem_rdata = mem_rd(dmem_addr);
        end
        wcnt = 0;
      end else begin
        dmem_resp = 1'b0;
        wcnt++;
      end
    end else begin
      dmem_resp = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int waits, input int budget);
    opcode = op; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    valid_in = 1'b1; resp_wait = waits; wcnt = 0;
    cyc = 0; stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; got_first = 1'b0; done = 1'b0;
    while (!done && cyc < budget) begin
      #1 respond();
      #1;
      cyc++;
      if (stall)      stall_cnt++;
      if (dmem_read)  rd_cnt++;
      if (dmem_write) wr_cnt++;
      if ((dmem_read || dmem_write) && !got_first) begin
        first_addr = dmem_addr;
        got_first  = 1'b1;
      end
      if (!stall) begin
        done       = 1'b1;
        rdata_cap  = rdata_out;
        last_addr  = dmem_addr;
        last_be    = dmem_byte_en;
        last_wdata = dmem_wdata;
      end
      @(negedge clk);
    end
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
    chk("op_completed", 32'(done), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 16'h0; wdata = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
    resp_wait = 0; wcnt = 0;
    mem[32'h1000] = 16'hBEEF;
    mem[32'h2000] = 16'h80FF;
    mem[32'h4000] = 16'h5000;
    mem[32'h5000] = 16'h1234;
    mem[32'h0040] = 16'h0400;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_read", 32'(dmem_read), 32'd0);
    chk("rst_write", 32'(dmem_write), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Stray response while idle must not start anything.
    dmem_resp = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_resp_stall", 32'(stall), 32'd0);
    chk("idle_resp_read", 32'(dmem_read), 32'd0);
    dmem_resp = 1'b0;
    @(negedge clk);

    // 1: LDR with two wait cycles
    run_op(op_ldr, 1'b1, 1'b0, 16'h1000, 16'h0, 2, 20);
    chk("ldr_cycles", 32'(cyc), 32'd4);
    chk("ldr_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("ldr_read_held", 32'(rd_cnt), 32'd3);
    chk("ldr_rdata", 32'(rdata_cap), 32'hBEEF);
    #1;
    chk("ldr_after_stall", 32'(stall), 32'd0);
    chk("ldr_after_read", 32'(dmem_read), 32'd0);
    @(negedge clk);

    // 2: LDB both lanes
    run_op(op_ldb, 1'b1, 1'b0, 16'h2001, 16'h0, 0, 10);
    chk("ldb_hi", 32'(rdata_cap), 32'hFF80);
    chk("ldb_cycles", 32'(cyc), 32'd2);
    run_op(op_ldb, 1'b1, 1'b0, 16'h2000, 16'h0, 0, 10);
    chk("ldb_lo", 32'(rdata_cap), 32'hFFFF);

    // 3: STB to the high byte, one wait
    run_op(op_stb, 1'b0, 1'b1, 16'h3001, 16'h12AB, 1, 10);
    chk("stb_be", 32'(last_be), 32'h2);
    chk("stb_wdata", 32'(last_wdata), 32'hABAB);
    chk("stb_write_held", 32'(wr_cnt), 32'd2);
    chk("stb_mem", 32'(mem_rd(16'h3000)), 32'hAB00);

    // 4: LDI through pointer
    run_op(op_ldi, 1'b1, 1'b0, 16'h4000, 16'h0, 0, 10);
    chk("ldi_ptr_addr", 32'(first_addr), 32'h4000);
    chk("ldi_acc_addr", 32'(last_addr), 32'h5000);
    chk("ldi_rdata", 32'(rdata_cap), 32'h1234);
    chk("ldi_cycles", 32'(cyc), 32'd3);
    chk("ldi_stall_cnt", 32'(stall_cnt), 32'd2);

    // 5: STI full-word write through pointer
    run_op(op_sti, 1'b0, 1'b1, 16'h4000, 16'h7777, 0, 10);
    chk("sti_ptr_addr", 32'(first_addr), 32'h4000);
    chk("sti_acc_addr", 32'(last_addr), 32'h5000);
    chk("sti_be", 32'(last_be), 32'h3);
    chk("sti_rd_wr", 32'({rd_cnt[7:0], wr_cnt[7:0]}), 32'h0101);
    chk("sti_mem", 32'(mem_rd(16'h5000)), 32'h7777);

    // 5b: reset while the pointer read is outstanding
    opcode = op_sti; mem_read = 1'b0; mem_write = 1'b1; addr = 16'h4000; valid_in = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_ind_read", 32'(dmem_read), 32'd1);
    reset_n = 1'b0; valid_in = 1'b0; mem_write = 1'b0;
    #1;
    chk("rst_async_read", 32'(dmem_read), 32'd0);
    chk("rst_async_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Write has priority when both controls are set
    run_op(op_str, 1'b1, 1'b1, 16'h6000, 16'h5A5A, 0, 10);
    chk("prio_rd_wr", 32'({rd_cnt[7:0], wr_cnt[7:0]}), 32'h0001);
    chk("prio_mem", 32'(mem_rd(16'h6000)), 32'h5A5A);

    // TRAP vector fetch is a plain word read
    run_op(op_trap, 1'b1, 1'b0, 16'h0040, 16'h0, 0, 10);
    chk("trap_rdata", 32'(rdata_cap), 32'h0400);

    // 6: no response at all -> timeout after 4 waits
    chk("pre_timeout", 32'(timeout_err), 32'd0);
    run_op(op_ldr, 1'b1, 1'b0, 16'h7000, 16'h0, 1000, 20);
    chk("to_cycles", 32'(cyc), 32'd6);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd5);
    #1;
    chk("to_flag", 32'(timeout_err), 32'd1);
    chk("to_idle_stall", 32'(stall), 32'd0);
    chk("to_idle_read", 32'(dmem_read), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
